tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
Hardware truth-table response checker, the consumer end of exhaustive combinational stimulus.
- Drives every minterm 0..2^N_IN-1 onto a DUT's inputs in ascending order and waits a settle window.
- Samples the DUT outputs, compares them against a parameterised expected truth table, and reports a per-row result stream plus a pass/fail summary.
- Sits beside a combinational DUT (e.g. the 3-input q6 function) in on-chip self-test or in a bench.

Parameters:
N_IN, 3, number of DUT inputs; minterm i drives bit N_IN-1 = A (MSB) ... bit 0 = C (LSB).
N_OUT, 1, number of DUT outputs.
SETTLE, 4, clock cycles each minterm is held before sampling; legal range >= 1.
EXPECTED, 8'h24, flattened truth table of width (2^N_IN)*N_OUT; outputs for minterm i are bits [i*N_OUT +: N_OUT]. The default encodes Y=1 at minterms 2 and 5.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; honoured only in IDLE
abort  input  1  cancel the running sweep; ignored in IDLE
dut_in  output  N_IN  stimulus to the DUT
dut_out  input  N_OUT  DUT response; combinational path assumed
busy  output  1  high while a sweep runs
row_valid  output  1  one-cycle strobe; row_* fields valid
row_minterm  output  N_IN  minterm just sampled
row_outputs  output  N_OUT  sampled dut_out
row_ok  output  1  row_outputs equals the expected slice
done  output  1  one-cycle strobe at sweep completion
pass  output  1  mismatch_count==0 for the last completed sweep
mismatch_count  output  N_IN+1  rows failing in the current or last sweep
hazard_seen  output  1  see Optional Feature

Behaviour:
Reset (any time, including mid-sweep): all outputs 0, state IDLE, minterm 0, settle counter 0.

States: IDLE, SETTLE, FINISH.

IDLE:
- start=1 at edge k: dut_in<=0, minterm<=0, settle_cnt<=0, mismatch_count<=0, pass<=0, busy<=1, state SETTLE.

SETTLE, at each edge:
- If settle_cnt < SETTLE-1: settle_cnt++.
- Else (sample edge):
  - row_valid<=1, row_minterm<=minterm, row_outputs<=dut_out, row_ok<=(dut_out==EXPECTED slice).
  - mismatch_count += !row_ok.
  - If minterm==2^N_IN-1: state FINISH. Otherwise minterm++, dut_in<=minterm+1, settle_cnt<=0.
- Rows are SETTLE cycles apart. The first row_valid rises SETTLE edges after the start edge.

FINISH (one cycle):
- done<=1, busy<=0, pass<=(mismatch_count==0), state IDLE.
- dut_in holds its last value.
- mismatch_count already includes the final row.

General rules:
- row_valid and done are single-cycle and deasserted otherwise.
- mismatch_count cannot overflow; maximum is 2^N_IN.
- abort=1 in SETTLE or FINISH: next edge busy<=0, state IDLE, done<=0, pass<=0, row_valid<=0. mismatch_count is frozen. abort has priority over a coincident sample edge; no row is emitted.
- start while busy is ignored. start and abort together in IDLE means start.
- SETTLE=1: every edge in SETTLE is a sample edge.

Optional Feature:
Macro HAZARD_DETECT_EN.
- With the macro: dut_out is registered each cycle in SETTLE. Each change after the first settle cycle of a row is counted.
  - A row whose counter exceeds 1 is hazardous, i.e. the output changed more than once within the window.
  - hazard_seen is sticky high from the sample edge of that row until the next start or reset.
- Without the macro: no detection logic; hazard_seen is tied 0.

Decomposition:
Package tt_check_pkg:
- State enum type tt_state_t {IDLE, SETTLE, FINISH}.
- Function expected_row(table, minterm, n_out) returning the slice.
- Localparam helper for the row count 2^N_IN.

One sub-module, tt_settle_timer:
- Ports: clk, rst_n, load, expire.
- Counts SETTLE cycles; asserts expire on the sample edge; load restarts it.

Test Plan:
1. Correct q6 model, SETTLE=4, pulse start → 8 row_valid strobes 4 cycles apart, row_ok=1 for each; row_outputs=1 at minterms 2 and 5 only; done at cycle 33 after start; pass=1; mismatch_count=0.
2. DUT stuck at 0 → row_ok=0 at minterms 2 and 5; mismatch_count=2; pass=0.
3. abort asserted during minterm 3 → busy low next cycle, no done, pass=0, mismatch_count frozen. A subsequent start runs a clean full sweep.
4. start re-pulsed at minterm 4 → ignored; sweep completes normally with exactly 8 rows.
5. rst_n low during minterm 6 → all outputs 0 immediately; after release, start gives a full sweep from minterm 0.
6. HAZARD_DETECT_EN: DUT model toggles 0→1→0→1 during the minterm-5 window → hazard_seen=1 after the row-5 sample, still pass=1. Without the macro, hazard_seen stays 0.

Source files
------------

// File: rtl/tt_check_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// State encoding, row-count helper and expected-slice extraction.
package tt_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FINISH
  } tt_state_t;

  localparam int TBL_W = 256;

  function automatic int rows_of(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic logic [31:0] expected_row(
    input logic [TBL_W-1:0] tbl,
    input int               minterm,
    input int               n_out
  );
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < n_out) r[b] = tbl[minterm*n_out+b];
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_sweep_checker_timer.sv
// Settle-window timer: expire marks the sample edge of a row.
// load holds the count at zero; expiry wraps it back to zero.
import tt_check_pkg::*;

module tt_settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == CW'(SETTLE - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (load || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep and response checker.
// Optional glitch detection in the settle window: HAZARD_DETECT_EN.
import tt_check_pkg::*;

module tt_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 4,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'h24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              row_valid,
  output logic [N_IN-1:0]   row_minterm,
  output logic [N_OUT-1:0]  row_outputs,
  output logic              row_ok,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_count,
  output logic              hazard_seen
);

  localparam int ROWS = rows_of(N_IN);
  localparam logic [N_IN-1:0] LAST = N_IN'(ROWS - 1);

  tt_state_t        state_q, state_d;
  logic [N_IN-1:0]  mt_q, mt_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;
  logic [N_IN-1:0]  rmin_q, rmin_d;
  logic [N_OUT-1:0] rout_q, rout_d;
  logic             rok_q, rok_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_IN:0]    mm_q, mm_d;

  logic             load, expire;
  logic [N_OUT-1:0] exp_row;
  logic             ok_now;

  assign load    = (state_q != ST_SETTLE);
  assign exp_row = N_OUT'(expected_row(TBL_W'(EXPECTED),
                                       int'(mt_q), N_OUT));
  assign ok_now  = (dut_out == exp_row);

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    busy_d  = busy_q;
    rv_d    = 1'b0;
    rmin_d  = rmin_q;
    rout_d  = rout_q;
    rok_d   = rok_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mm_d    = mm_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mt_d    = '0;
          mm_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (expire) begin
          rv_d   = 1'b1;
          rmin_d = mt_q;
          rout_d = dut_out;
          rok_d  = ok_now;
          mm_d   = mm_q + (N_IN+1)'(!ok_now);
          if (mt_q == LAST) state_d = ST_FINISH;
          else              mt_d = mt_q + N_IN'(1);
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (abort) begin
          pass_d = 1'b0;
        end else begin
          done_d = 1'b1;
          pass_d = (mm_q == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mt_q    <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      rmin_q  <= '0;
      rout_q  <= '0;
      rok_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      rmin_q  <= rmin_d;
      rout_q  <= rout_d;
      rok_q   <= rok_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
    end
  end

  assign dut_in         = mt_q;
  assign busy           = busy_q;
  assign row_valid      = rv_q;
  assign row_minterm    = rmin_q;
  assign row_outputs    = rout_q;
  assign row_ok         = rok_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_count = mm_q;

`ifdef HAZARD_DETECT_EN
  // The first cycle of a row is excluded: dut_in just moved there.
  logic [N_OUT-1:0] prev_q;
  logic [1:0]       chg_q, chg_nx;
  logic             first_q, hz_q;

  always_comb begin
    chg_nx = chg_q;
    if (!first_q && dut_out != prev_q && chg_q != 2'd3)
      chg_nx = chg_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      chg_q   <= '0;
      first_q <= 1'b0;
      hz_q    <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      chg_q   <= '0;
      first_q <= 1'b1;
      hz_q    <= 1'b0;
    end else if (state_q == ST_SETTLE && !abort) begin
      prev_q <= dut_out;
      if (expire) begin
        chg_q   <= '0;
        first_q <= 1'b1;
        if (chg_nx > 2'd1) hz_q <= 1'b1;
      end else begin
        chg_q   <= chg_nx;
        first_q <= 1'b0;
      end
    end
  end

  assign hazard_seen = hz_q;
`else
  assign hazard_seen = 1'b0;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker against a q6 model.
// Covers clean/stuck sweeps, abort, restart, reset, glitch.
module tb_tt_sweep_checker;

`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] dut_in;
  logic [0:0] dut_out;
  logic       busy, row_valid, row_ok, done, pass;
  logic [2:0] row_minterm;
  logic [0:0] row_outputs;
  logic [3:0] mismatch_count;
  logic       hazard_seen;

  logic stuck  = 1'b0;
  logic force0 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic model(input logic [2:0] m);
    return (m == 3'd2) || (m == 3'd5);
  endfunction

  assign dut_out = (force0 || stuck) ? 1'b0 : model(dut_in);

  tt_sweep_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .dut_in         (dut_in),
    .dut_out        (dut_out),
    .busy           (busy),
    .row_valid      (row_valid),
    .row_minterm    (row_minterm),
    .row_outputs    (row_outputs),
    .row_ok         (row_ok),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .hazard_seen    (hazard_seen)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int ab_at, input int rs_at,
                       input int rst_at, input bit glitch,
                       output int nrows, output int done_c);
    logic em;
    nrows  = 0;
    done_c = -1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start", 32'(busy), 1);
    for (int c = 1; c <= 60; c++) begin
      abort  = (c == ab_at);
      start  = (c == rs_at);
      force0 = glitch && (c == 22);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      tick();
      if (row_valid) begin
        em = model(3'(nrows));
        chk("row_min", 32'(row_minterm), 32'(nrows));
        chk("row_out", 32'(row_outputs), stuck ? 0 : 32'(em));
        chk("row_ok", 32'(row_ok), stuck ? 32'(!em) : 1);
        chk("row_time", 32'(c), 32'(4 * (nrows + 1)));
        nrows++;
      end
      if (done) begin
        done_c = c;
        break;
      end
      if (ab_at > 0 && c >= ab_at && !busy) break;
    end
    abort  = 1'b0;
    start  = 1'b0;
    force0 = 1'b0;
  endtask

  initial begin
    int nr, dc;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dut_in", 32'(dut_in), 0);
    chk("rst_mm", 32'(mismatch_count), 0);
    chk("rst_pass", 32'(pass), 0);
    rst_n = 1'b1;
    tick();

    // clean q6 sweep
    sweep(0, 0, 0, 1'b0, nr, dc);
    chk("t1_rows", 32'(nr), 8);
    chk("t1_done_c", 32'(dc), 33);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_mm", 32'(mismatch_count), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_dut_in", 32'(dut_in), 7);
    chk("t1_hz", 32'(hazard_seen), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);

    // stuck-at-0 DUT
    stuck = 1'b1;
    sweep(0, 0, 0, 1'b0, nr, dc);
    chk("t2_rows", 32'(nr), 8);
    chk("t2_mm", 32'(mismatch_count), 2);
    chk("t2_pass", 32'(pass), 0);
    tick();

    // abort during minterm 3, stuck DUT
    sweep(14, 0, 0, 1'b0, nr, dc);
    chk("t3_rows", 32'(nr), 3);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_mm", 32'(mismatch_count), 1);
    chk("t3_pass", 32'(pass), 0);
    chk("t3_nodone", 32'(dc), 32'(-1));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_idle_done", 32'(done), 0);
    end
    stuck = 1'b0;
    sweep(0, 0, 0, 1'b0, nr, dc);
    chk("t3b_rows", 32'(nr), 8);
    chk("t3b_pass", 32'(pass), 1);
    tick();

    // start re-pulsed at minterm 4
    sweep(0, 18, 0, 1'b0, nr, dc);
    chk("t4_rows", 32'(nr), 8);
    chk("t4_done_c", 32'(dc), 33);
    chk("t4_pass", 32'(pass), 1);
    tick();

    // reset during minterm 6
    stuck = 1'b1;
    sweep(0, 0, 26, 1'b0, nr, dc);
    chk("t5_rows", 32'(nr), 6);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_dut_in", 32'(dut_in), 0);
    chk("t5_mm", 32'(mismatch_count), 0);
    chk("t5_rv", 32'(row_valid), 0);
    chk("t5_rmin", 32'(row_minterm), 0);
    chk("t5_pass", 32'(pass), 0);
    tick();
    rst_n = 1'b1;
    tick();
    stuck = 1'b0;
    sweep(0, 0, 0, 1'b0, nr, dc);
    chk("t5b_rows", 32'(nr), 8);
    chk("t5b_pass", 32'(pass), 1);
    tick();

    // glitch during the minterm-5 window
    sweep(0, 0, 0, 1'b1, nr, dc);
    chk("t6_rows", 32'(nr), 8);
    chk("t6_pass", 32'(pass), 1);
    chk("t6_mm", 32'(mismatch_count), 0);
    chk("t6_hz", 32'(hazard_seen), 32'(HZ));
    tick();
    chk("t6_hz_sticky", 32'(hazard_seen), 32'(HZ));

    // hazard cleared by a fresh start
    sweep(0, 0, 0, 1'b0, nr, dc);
    chk("t7_hz", 32'(hazard_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
